// File: rtl/pmc_pkg.sv
// Shared PMC types and constants: data word layout, shift FSM states and
// control/status register layouts.
package pmc_pkg;

   localparam int PMC_LANES          = 16;
   localparam int PMC_WORD_W         = 32;
   localparam int PMC_DIV_W          = 8;
   localparam int PMC_SHIFT_MAX_BITS = 32;

   typedef logic [PMC_LANES-1:0][PMC_WORD_W-1:0] pmc_data_t;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} pmc_shift_state_t;

   typedef struct packed {
      logic [24:0] res;
      logic [5:0]  bit_count;
      logic        shift_start;
   } pmc_cr_t;

   typedef struct packed {
      logic [30:0] res;
      logic        shift_busy;
   } pmc_sr_t;

   // 0 and anything above the word width both mean a full word
   function automatic logic [5:0] pmc_eff_bits(input logic [5:0] bc);
      return (bc == 6'd0 || bc > 6'(PMC_SHIFT_MAX_BITS)) ? 6'(PMC_SHIFT_MAX_BITS) : bc;
   endfunction

endpackage

// File: rtl/pmc_shift_clkgen.sv
// Half-period divider for the matrix shift clock; phase_end marks the last
// clk cycle of each LOW/HIGH phase.
module pmc_shift_clkgen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             phase_end
);

   logic [DIV_W-1:0] cnt;

   assign phase_end = run && (cnt == div);

   always_ff @(posedge clk) begin
      if (rst || !run || phase_end) cnt <= '0;
      else                          cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/pmc_shift_engine.sv
// Serial shift engine: shifts dout words MSB-first over parallel lanes with a
// divided shift clock while capturing the returning streams into din words.
module pmc_shift_engine
   import pmc_pkg::*;
#(
   parameter int LANES  = PMC_LANES,
   parameter int WORD_W = PMC_WORD_W,
   parameter int DIV_W  = PMC_DIV_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [5:0]                    bit_count,
   input  logic [DIV_W-1:0]              clk_div,
   input  logic [LANES-1:0][WORD_W-1:0]  dout_i,
   output logic [LANES-1:0][WORD_W-1:0]  din_o,
   output logic                          busy,
   output logic                          done,
   output logic                          mtx_clk_sh,
   output logic [LANES-1:0]              mtx_dout,
   input  logic [LANES-1:0]              mtx_din
);

   pmc_shift_state_t                state;
   logic [LANES-1:0][WORD_W-1:0]    sh_q, sh_nxt;
   logic [LANES-1:0][WORD_W-1:0]    cap_q, cap_nxt;
   logic [5:0]                      cnt_q;
   logic [DIV_W-1:0]                div_q;
   logic                            run, phase_end;

   assign run = (state == LOW) || (state == HIGH);

   pmc_shift_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .div       (div_q),
      .phase_end (phase_end)
   );

   // mtx_dout comes straight off the shift register MSBs, so it only moves
   // when the register loads at start or shifts on the clk_sh falling edge
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign sh_nxt[k]   = {sh_q[k][WORD_W-2:0], 1'b0};
      assign cap_nxt[k]  = {cap_q[k][WORD_W-2:0], mtx_din[k]};
      assign mtx_dout[k] = sh_q[k][WORD_W-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sh_q       <= '0;
         cap_q      <= '0;
         cnt_q      <= '0;
         div_q      <= '0;
         din_o      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mtx_clk_sh <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sh_q  <= dout_i;
               cap_q <= '0;
               cnt_q <= pmc_eff_bits(bit_count);
               div_q <= clk_div;
               busy  <= 1'b1;
               state <= LOW;
            end
            LOW: if (phase_end) begin
               mtx_clk_sh <= 1'b1;
               state      <= HIGH;
            end
            HIGH: if (phase_end) begin
               mtx_clk_sh <= 1'b0;
               sh_q       <= sh_nxt;
               cap_q      <= cap_nxt;
               cnt_q      <= cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  state <= LOW;
               end
            end
            FIN: begin
               din_o <= cap_q;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmc_shift_engine.sv
// Directed bench for pmc_shift_engine: loopback, partial word, back-to-back,
// mid-transfer reset and input stability scenarios.
module tb_pmc_shift_engine;
   import pmc_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [5:0]          bit_count = '0;
   logic [7:0]          clk_div = '0;
   logic [15:0][31:0]   dout_v = '0;
   logic [15:0][31:0]   din_o;
   logic                busy, done, mtx_clk_sh;
   logic [15:0]         mtx_dout, mtx_din;
   logic [15:0]         din_drv = '0;
   logic                loop_en = 1'b0;
   logic [31:0]         din_bits = '0;
   int                  total = 0;
   int                  bad = 0;

   assign mtx_din = loop_en ? mtx_dout : din_drv;

   always #5 clk = ~clk;

   pmc_shift_engine dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bit_count  (bit_count),
      .clk_div    (clk_div),
      .dout_i     (dout_v),
      .din_o      (din_o),
      .busy       (busy),
      .done       (done),
      .mtx_clk_sh (mtx_clk_sh),
      .mtx_dout   (mtx_dout),
      .mtx_din    (mtx_din)
   );

   task automatic step();
      @(posedge clk); #1;
   endtask

   // start accepted in cycle 0; returns at the cycle-1 sample point
   task automatic launch();
      start = 1'b1; step(); start = 1'b0;
   endtask

   // Runs from cycle 1 until done (bounded), recording shift clock behaviour
   // and the lane-0 bit seen at each rising edge of clk_sh.
   task automatic measure(input int chg_cyc, input int poke_cyc,
                          output int done_cyc, output int pulses, output int per,
                          output int per_bad, output int hi_cyc,
                          output logic busy_done, output logic [31:0] tx0);
      int   last_rise = -1;
      logic prev = 1'b0;
      done_cyc = -1; pulses = 0; per = -1; per_bad = 0; hi_cyc = 0;
      busy_done = 1'b1; tx0 = '0;
      for (int cyc = 1; cyc < 3000; cyc++) begin
         if (mtx_clk_sh && !prev) begin
            tx0 = {tx0[30:0], mtx_dout[0]};
            if (last_rise >= 0) begin
               if (per < 0) per = cyc - last_rise;
               else if (cyc - last_rise != per) per_bad++;
            end
            last_rise = cyc;
            pulses++;
         end
         if (mtx_clk_sh) hi_cyc++;
         prev = mtx_clk_sh;
         if (done) begin done_cyc = cyc; busy_done = busy; break; end
         if (!mtx_clk_sh && pulses < 32) din_drv[0] = din_bits[31-pulses];
         start = (cyc == poke_cyc);
         if (cyc == chg_cyc) begin
            dout_v = {16{32'hFFFF_FFFF}}; clk_div = 8'd5; bit_count = 6'd3;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic idle_bad = 1'b0;
      rst = 1'b1; step(); step();
      total++; if (din_o !== '0) begin bad++; $display("FAIL rst_din_o got=%h exp=0", din_o); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (mtx_clk_sh !== 1'b0) begin bad++; $display("FAIL rst_clk_sh got=%b exp=0", mtx_clk_sh); end
      total++; if (mtx_dout !== 16'h0) begin bad++; $display("FAIL rst_mtx_dout got=%h exp=0", mtx_dout); end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (busy !== 1'b0 || mtx_clk_sh !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
      end
      total++; if (idle_bad !== 1'b0) begin bad++; $display("FAIL idle_quiet got=%b exp=0", idle_bad); end
   endtask

   task automatic test_loopback();
      int dc, np, per, pb, hc; logic bd; logic [31:0] tx;
      for (int k = 0; k < 16; k++) dout_v[k] = 32'hA5A5_0000 + 32'(k);
      loop_en = 1'b1; bit_count = 6'd0; clk_div = 8'd0;
      launch();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL lb_busy_c1 got=%b exp=1", busy); end
      total++; if (mtx_dout !== 16'hFFFF) begin bad++; $display("FAIL lb_dout_c1 got=%h exp=ffff", mtx_dout); end
      total++; if (mtx_clk_sh !== 1'b0) begin bad++; $display("FAIL lb_sh_c1 got=%b exp=0", mtx_clk_sh); end
      measure(-1, -1, dc, np, per, pb, hc, bd, tx);
      total++; if (dc !== 65) begin bad++; $display("FAIL lb_done_cyc got=%0d exp=65", dc); end
      total++; if (np !== 32) begin bad++; $display("FAIL lb_pulses got=%0d exp=32", np); end
      total++; if (per !== 2 || pb !== 0) begin bad++; $display("FAIL lb_period got=%0d/%0d exp=2/0", per, pb); end
      total++; if (hc !== 32) begin bad++; $display("FAIL lb_high_cyc got=%0d exp=32", hc); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL lb_busy_done got=%b exp=0", bd); end
      total++; if (tx !== 32'hA5A5_0000) begin bad++; $display("FAIL lb_tx0 got=%h exp=a5a50000", tx); end
      step();
      total++; if (din_o !== dout_v) begin bad++; $display("FAIL lb_din_o got=%h exp=%h", din_o, dout_v); end
      step(); step();
      total++; if (din_o !== dout_v) begin bad++; $display("FAIL lb_din_hold got=%h exp=%h", din_o, dout_v); end
   endtask

   task automatic test_partial();
      int dc, np, per, pb, hc; logic bd; logic [31:0] tx;
      loop_en = 1'b0; dout_v = '0; dout_v[0] = 32'hF000_0000;
      din_bits = 32'hB000_0000; bit_count = 6'd4; clk_div = 8'd2;
      launch();
      measure(-1, -1, dc, np, per, pb, hc, bd, tx);
      total++; if (dc !== 25) begin bad++; $display("FAIL pw_done_cyc got=%0d exp=25", dc); end
      total++; if (np !== 4) begin bad++; $display("FAIL pw_pulses got=%0d exp=4", np); end
      total++; if (per !== 6 || pb !== 0) begin bad++; $display("FAIL pw_period got=%0d/%0d exp=6/0", per, pb); end
      total++; if (hc !== 12) begin bad++; $display("FAIL pw_high_cyc got=%0d exp=12", hc); end
      total++; if (tx !== 32'h0000_000F) begin bad++; $display("FAIL pw_tx0 got=%h exp=0000000f", tx); end
      step();
      total++; if (din_o[0] !== 32'h0000_000B) begin bad++; $display("FAIL pw_din0 got=%h exp=0000000b", din_o[0]); end
      total++; if (din_o[1] !== 32'h0) begin bad++; $display("FAIL pw_din1 got=%h exp=0", din_o[1]); end
   endtask

   task automatic test_back_to_back();
      int dc, np, per, pb, hc; logic bd; logic [31:0] tx;
      for (int k = 0; k < 16; k++) dout_v[k] = 32'h8000_0000 + 32'(k);
      loop_en = 1'b1; bit_count = 6'd1; clk_div = 8'd0;
      launch();
      measure(-1, 2, dc, np, per, pb, hc, bd, tx);
      total++; if (dc !== 3) begin bad++; $display("FAIL bb_done1_cyc got=%0d exp=3", dc); end
      total++; if (np !== 1) begin bad++; $display("FAIL bb_pulses1 got=%0d exp=1", np); end
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bb_busy_after got=%b exp=0", busy); end
      total++; if (din_o !== {16{32'h0000_0001}}) begin bad++; $display("FAIL bb_din1 got=%h exp=all 00000001", din_o); end
      bit_count = 6'd40;
      launch();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bb_busy2 got=%b exp=1", busy); end
      measure(-1, -1, dc, np, per, pb, hc, bd, tx);
      total++; if (dc !== 65) begin bad++; $display("FAIL bb_done2_cyc got=%0d exp=65", dc); end
      total++; if (np !== 32) begin bad++; $display("FAIL bb_pulses2 got=%0d exp=32", np); end
      step();
      total++; if (din_o !== dout_v) begin bad++; $display("FAIL bb_din2 got=%h exp=%h", din_o, dout_v); end
   endtask

   task automatic test_reset_mid();
      int dc, np, per, pb, hc; logic bd; logic [31:0] tx;
      logic done_seen = 1'b0;
      for (int k = 0; k < 16; k++) dout_v[k] = 32'h1234_5678 ^ 32'(k);
      loop_en = 1'b1; bit_count = 6'd32; clk_div = 8'd0;
      launch();
      for (int c = 1; c < 20; c++) step();
      rst = 1'b1; step();
      total++; if (mtx_clk_sh !== 1'b0) begin bad++; $display("FAIL rm_clk_sh got=%b exp=0", mtx_clk_sh); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
      total++; if (din_o !== '0) begin bad++; $display("FAIL rm_din_o got=%h exp=0", din_o); end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (done !== 1'b0) done_seen = 1'b1;
         step();
      end
      total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL rm_no_done got=%b exp=0", done_seen); end
      launch();
      measure(-1, -1, dc, np, per, pb, hc, bd, tx);
      total++; if (dc !== 65) begin bad++; $display("FAIL rm_done_cyc got=%0d exp=65", dc); end
      step();
      total++; if (din_o !== dout_v) begin bad++; $display("FAIL rm_din_o2 got=%h exp=%h", din_o, dout_v); end
   endtask

   task automatic test_stability();
      int dc, np, per, pb, hc; logic bd; logic [31:0] tx;
      for (int k = 0; k < 16; k++) dout_v[k] = {8'h5A + 8'(k), 24'h0};
      loop_en = 1'b1; bit_count = 6'd8; clk_div = 8'd1;
      launch();
      measure(3, -1, dc, np, per, pb, hc, bd, tx);
      total++; if (dc !== 33) begin bad++; $display("FAIL st_done_cyc got=%0d exp=33", dc); end
      total++; if (np !== 8) begin bad++; $display("FAIL st_pulses got=%0d exp=8", np); end
      total++; if (per !== 4 || pb !== 0) begin bad++; $display("FAIL st_period got=%0d/%0d exp=4/0", per, pb); end
      total++; if (hc !== 16) begin bad++; $display("FAIL st_high_cyc got=%0d exp=16", hc); end
      total++; if (tx !== 32'h0000_005A) begin bad++; $display("FAIL st_tx0 got=%h exp=0000005a", tx); end
      step();
      total++; if (din_o[0] !== 32'h0000_005A) begin bad++; $display("FAIL st_din0 got=%h exp=0000005a", din_o[0]); end
      total++; if (din_o[1] !== 32'h0000_005B) begin bad++; $display("FAIL st_din1 got=%h exp=0000005b", din_o[1]); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_partial();
      test_back_to_back();
      test_reset_mid();
      test_stability();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pmc_shift_engine.md
Name: pmc_shift_engine

Overview:
Serial shift engine between the PMC register file and the pixel matrix. On a start request it shifts up to 32 bits from each of the 16 dout words into the matrix over 16 parallel serial lanes, generating clk_sh. It captures the 16 returning serial streams into din words at the same time. The register file triggers it and reads back din and status.

Parameters:
LANES, 16, number of parallel serial lanes (one dout/din word per lane)
WORD_W, 32, bits per lane word
DIV_W, 8, width of the clk_sh half-period divider

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
bit_count  input  6  bits to shift per lane, 1..32; value 0 or any value >32 is treated as 32
clk_div  input  DIV_W  clk_sh half-period minus one, in clk cycles
dout_i  input  LANES*WORD_W  words to shift out (pmc_data_t layout, lane k = word k)
din_o  output  LANES*WORD_W  captured words (pmc_data_t layout)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when a transfer completes
mtx_clk_sh  output  1  shift clock to the matrix
mtx_dout  output  LANES  serial data to the matrix, lane k = bit k
mtx_din  input  LANES  serial data from the matrix

Behaviour:
- Reset: all outputs 0 (din_o, busy, done, mtx_clk_sh, mtx_dout); FSM goes to IDLE; counters are cleared. Reset mid-transfer aborts immediately: clk_sh drops low and din_o is cleared. No done pulse is issued.
- States: IDLE, LOW, HIGH, FIN.
- IDLE: start=1 latches dout_i into the shift register, latches the effective bit_count (N) and clk_div (D), and clears the capture register. The FSM goes to LOW. start while not in IDLE is ignored.
- LOW: mtx_clk_sh=0; mtx_dout[k] = MSB of shift word k. The FSM stays D+1 cycles, then goes to HIGH.
- HIGH: mtx_clk_sh=1; mtx_dout is held. The FSM stays D+1 cycles. On the last HIGH cycle:
  - capture word k <= {capture[k][WORD_W-2:0], mtx_din[k]};
  - shift word k <= shift word k << 1 (zero fill);
  - the bit counter decrements.
  If the counter reaches 0, the FSM goes to FIN; otherwise it goes to LOW.
- FIN: one cycle. din_o <= capture register, done=1, busy=0 in this same cycle. The FSM returns to IDLE.
- din_o changes only in FIN or on reset. It holds its value between transfers.
- The bit first received from the matrix lands in the highest used position. For N<32, captured bits occupy din_o bits [N-1:0] and the upper bits are 0.
- Only the top N bits of each dout word (bits [31:32-N]) are transmitted, MSB first.
- Timing, with start accepted in cycle 0:
  - first LOW cycle is cycle 1;
  - each bit takes 2(D+1) cycles;
  - done is high in cycle 1+2N(D+1).
  - Example: N=32, D=0 gives done in cycle 65.
- busy is 1 in cycles 1 .. 2N(D+1) and 0 in the done cycle, so a new start is accepted in the cycle after done.
- Changes to clk_div, bit_count or dout_i during a transfer have no effect.
- mtx_clk_sh is a registered output with no glitches. mtx_dout changes only on clk_sh falling transitions or at transfer start.

Decomposition:
- pmc_pkg additions:
  - enum pmc_shift_state_t {IDLE, LOW, HIGH, FIN};
  - constant PMC_SHIFT_MAX_BITS = 32;
  - reuse pmc_data_t for dout_i/din_o.
- New CR fields (shift_start, bit_count) and SR fields (shift_busy) are added to the existing struct res bits.
- One natural sub-module: pmc_shift_clkgen. It holds the half-period divider counter and produces phase_end, a pulse on the last cycle of each LOW/HIGH phase. The FSM and lane shift/capture registers stay in pmc_shift_engine.

Test Plan:
- Reset then idle: after rst all outputs 0; start never asserted -> busy stays 0, mtx_clk_sh stays 0.
- Full loopback: mtx_din = mtx_dout, dout word k = 32'hA5A5_0000+k, bit_count=0 (32), clk_div=0 -> 32 clk_sh pulses of period 2; done in cycle 65; din_o == dout_i exactly.
- Partial word: bit_count=4, clk_div=2, dout word 0 = 32'hF000_0000, mtx_din[0] driven 1,0,1,1 per bit -> 4 pulses of 6-cycle period; done in cycle 25; din_o word 0 = 32'h0000_000B; mtx_dout[0] = 1 on all 4 bits.
- Ignored start / back-to-back: start pulsed while busy=1 -> no effect; start in the cycle after done -> second transfer begins and busy=1 next cycle.
- Reset mid-transfer: rst at cycle 20 of a 32-bit, clk_div=0 run -> next cycle mtx_clk_sh=0, busy=0, din_o=0, no done pulse; a fresh start afterwards completes normally.
- Input stability: change dout_i, clk_div and bit_count during a transfer -> pulse count, period and transmitted data match the values latched at start.
